// File: rtl/rc4_stream_xor.sv
// Consumer side of an RC4 keystream: buffers keystream bytes, optionally discards the
// first DROP_N after each start, and XORs the rest one-for-one onto a valid/ready byte stream.
module rc4_stream_xor #(
    parameter int unsigned KS_DEPTH = 16,
    parameter int unsigned DROP_N   = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             ks_flush_o,
    input  logic             ks_valid_i,
    input  logic [7:0]       ks_data_i,
    output logic             ks_ready_o,
    input  logic             din_valid_i,
    input  logic [7:0]       din_data_i,
    input  logic             din_last_i,
    output logic             din_ready_o,
    output logic             dout_valid_o,
    output logic [7:0]       dout_data_o,
    output logic             dout_last_o,
    input  logic             dout_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] byte_cnt_o
);

    localparam int unsigned AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 16;
    localparam logic [CW-1:0] FULL_LVL = CW'(KS_DEPTH);
    localparam logic [DW-1:0] DROP_LD  = DW'(DROP_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DROP  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [KS_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    drop_q, drop_d;
    logic             ks_ready_q, ks_ready_d;
    logic             ks_flush_q, ks_flush_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dout_valid_q, dout_valid_d;
    logic [7:0]       dout_data_q, dout_data_d;
    logic             dout_last_q, dout_last_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic fifo_empty;
    logic push;
    logic pop;
    logic drop_pop;
    logic din_ready;
    logic din_hs;
    logic dout_hs;
    logic clear;

    // Handshake decode; din_ready must follow dout_ready combinationally for 1 byte/cycle.
    always_comb begin
        fifo_empty = (count_q == '0);
        push       = ks_valid_i & ks_ready_q;
        din_ready  = (state_q == S_RUN) & ~fifo_empty & (~dout_valid_q | dout_ready_i);
        din_hs     = din_valid_i & din_ready;
        dout_hs    = dout_valid_q & dout_ready_i;
        drop_pop   = (state_q == S_DROP) & ~fifo_empty;
        pop        = din_hs | drop_pop;
    end

    // Next-state and control pulses.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        ks_flush_d = 1'b0;
        done_d     = 1'b0;
        clear      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ks_flush_d = 1'b1;
                    clear      = 1'b1;
                    drop_d     = DROP_LD;
                    state_d    = (DROP_N > 0) ? S_DROP : S_RUN;
                end
            end
            S_DROP: begin
                if (drop_pop) begin
                    drop_d = drop_q - DW'(1);
                    if (drop_q == DW'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (din_hs && din_last_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dout_hs && dout_last_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers; any keystream still buffered is dropped whenever the block goes idle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (clear || (state_d == S_IDLE)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        ks_ready_d = (state_d != S_IDLE) && (count_d != FULL_LVL);
        busy_d     = (state_d != S_IDLE);
    end

    // Output register: load on din handshake, empty on dout handshake, otherwise hold.
    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_last_d  = dout_last_q;
        if (din_hs) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data_i ^ mem_q[rd_ptr_q];
            dout_last_d  = din_last_i;
        end else if (dout_hs) begin
            dout_valid_d = 1'b0;
        end
        byte_cnt_d = clear ? '0 : (byte_cnt_q + CNT_W'(dout_hs));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_q       <= '0;
            ks_ready_q   <= 1'b0;
            ks_flush_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_last_q  <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            ks_ready_q   <= ks_ready_d;
            ks_flush_q   <= ks_flush_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_last_q  <= dout_last_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    // Keystream storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ks_data_i;
        end
    end

    no_pop_on_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && fifo_empty));
    no_push_on_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && (count_q == FULL_LVL)));

    assign ks_flush_o   = ks_flush_q;
    assign ks_ready_o   = ks_ready_q;
    assign din_ready_o  = din_ready;
    assign dout_valid_o = dout_valid_q;
    assign dout_data_o  = dout_data_q;
    assign dout_last_o  = dout_last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Directed bench for rc4_stream_xor: one instance without drop, one with DROP_N=3
// sharing all stream inputs but with separate start.
module tb_rc4_stream_xor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic        ks_valid;
    logic [7:0]  ks_data;
    logic        din_valid;
    logic [7:0]  din_data;
    logic        din_last;
    logic        dout_ready;

    logic        ks_flush, ks_ready, din_ready, dout_valid, dout_last, busy, done;
    logic [7:0]  dout_data;
    logic [15:0] byte_cnt;

    logic        ks_flush3, ks_ready3, din_ready3, dout_valid3, dout_last3, busy3, done3;
    logic [7:0]  dout_data3;
    logic [15:0] byte_cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rc4_stream_xor #(.KS_DEPTH(16), .DROP_N(0), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ks_flush_o(ks_flush),
        .ks_valid_i(ks_valid), .ks_data_i(ks_data), .ks_ready_o(ks_ready),
        .din_valid_i(din_valid), .din_data_i(din_data), .din_last_i(din_last),
        .din_ready_o(din_ready), .dout_valid_o(dout_valid), .dout_data_o(dout_data),
        .dout_last_o(dout_last), .dout_ready_i(dout_ready), .busy_o(busy),
        .done_o(done), .byte_cnt_o(byte_cnt)
    );

    rc4_stream_xor #(.KS_DEPTH(16), .DROP_N(3), .CNT_W(16)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .ks_flush_o(ks_flush3),
        .ks_valid_i(ks_valid), .ks_data_i(ks_data), .ks_ready_o(ks_ready3),
        .din_valid_i(din_valid), .din_data_i(din_data), .din_last_i(din_last),
        .din_ready_o(din_ready3), .dout_valid_o(dout_valid3), .dout_data_o(dout_data3),
        .dout_last_o(dout_last3), .dout_ready_i(dout_ready), .busy_o(busy3),
        .done_o(done3), .byte_cnt_o(byte_cnt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; start3 = 0; ks_valid = 0; ks_data = 0;
        din_valid = 0; din_data = 0; din_last = 0; dout_ready = 1;
        tick(); tick();
        n_cmp++; if (ks_flush !== 1'b0)   begin n_err++; $display("FAIL reset_ks_flush: got %b want 0", ks_flush); end
        n_cmp++; if (ks_ready !== 1'b0)   begin n_err++; $display("FAIL reset_ks_ready: got %b want 0", ks_ready); end
        n_cmp++; if (din_ready !== 1'b0)  begin n_err++; $display("FAIL reset_din_ready: got %b want 0", din_ready); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        n_cmp++; if (dout_data !== 8'h00) begin n_err++; $display("FAIL reset_dout_data: got %h want 00", dout_data); end
        n_cmp++; if (dout_last !== 1'b0)  begin n_err++; $display("FAIL reset_dout_last: got %b want 0", dout_last); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (byte_cnt !== 16'd0)  begin n_err++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
        n_cmp++; if (busy3 !== 1'b0)      begin n_err++; $display("FAIL reset_busy3: got %b want 0", busy3); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] din_v [4];
        logic [7:0] exp_v [4];
        din_v = '{8'h10, 8'h20, 8'h30, 8'h40};
        exp_v = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start();
        n_cmp++; if (ks_flush !== 1'b1) begin n_err++; $display("FAIL basic_flush: got %b want 1", ks_flush); end
        n_cmp++; if (ks_ready !== 1'b1) begin n_err++; $display("FAIL basic_ks_ready: got %b want 1", ks_ready); end
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1; ks_data = 8'(i + 1);
            tick();
            if (i == 0) begin
                n_cmp++; if (ks_flush !== 1'b0) begin n_err++; $display("FAIL basic_flush_pulse: got %b want 0", ks_flush); end
            end
        end
        ks_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1; din_data = din_v[i]; din_last = (i == 3);
            tick();
            n_cmp++; if (dout_valid !== 1'b1 || dout_data !== exp_v[i] || dout_last !== (i == 3))
                begin n_err++; $display("FAIL basic_dout%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, dout_valid, dout_data, dout_last, exp_v[i], (i == 3)); end
        end
        din_valid = 1'b0; din_last = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL basic_done: got done=%b v=%b busy=%b want 1 0 0", done, dout_valid, busy); end
        n_cmp++; if (byte_cnt !== 16'd4) begin n_err++; $display("FAIL basic_byte_cnt: got %0d want 4", byte_cnt); end
        tick();
        n_cmp++; if (done !== 1'b0 || byte_cnt !== 16'd4)
            begin n_err++; $display("FAIL basic_done_pulse: got done=%b cnt=%0d want 0 4", done, byte_cnt); end
    endtask

    task automatic test_drop();
        logic [7:0] ks_v [4];
        ks_v = '{8'hAA, 8'hBB, 8'hCC, 8'h5A};
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n_cmp++; if (ks_flush3 !== 1'b1 || busy3 !== 1'b1)
            begin n_err++; $display("FAIL drop_start: got flush=%b busy=%b want 1 1", ks_flush3, busy3); end
        din_valid = 1'b1; din_data = 8'hFF; din_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1; ks_data = ks_v[i];
            #1;
            n_cmp++; if (din_ready3 !== 1'b0) begin n_err++; $display("FAIL drop_din_ready%0d: got %b want 0", i, din_ready3); end
            tick();
        end
        ks_valid = 1'b0;
        #1;
        n_cmp++; if (din_ready3 !== 1'b1) begin n_err++; $display("FAIL drop_run_ready: got %b want 1", din_ready3); end
        tick();
        din_valid = 1'b0; din_last = 1'b0;
        n_cmp++; if (dout_valid3 !== 1'b1 || dout_data3 !== 8'hA5 || dout_last3 !== 1'b1)
            begin n_err++; $display("FAIL drop_dout: got v=%b d=%h l=%b want 1 a5 1", dout_valid3, dout_data3, dout_last3); end
        tick();
        n_cmp++; if (done3 !== 1'b1 || byte_cnt3 !== 16'd1)
            begin n_err++; $display("FAIL drop_done: got done=%b cnt=%0d want 1 1", done3, byte_cnt3); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d_v [6];
        logic [7:0] e_v [6];
        d_v = '{8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h3C, 8'hC3};
        e_v = '{8'h3F, 8'hC1, 8'h67, 8'h99, 8'h08, 8'hF6};
        do_start();
        for (int i = 0; i < 16; i++) begin
            ks_valid = 1'b1; ks_data = 8'(8'h30 + i);
            tick();
            if (i == 14) begin
                n_cmp++; if (ks_ready !== 1'b1) begin n_err++; $display("FAIL bp_ks_ready_15: got %b want 1", ks_ready); end
            end
        end
        n_cmp++; if (ks_ready !== 1'b0) begin n_err++; $display("FAIL bp_ks_ready_full: got %b want 0", ks_ready); end
        ks_data = 8'hEE;
        tick();
        ks_valid = 1'b0;
        din_valid = 1'b1; din_data = d_v[0]; din_last = 1'b0;
        tick();
        n_cmp++; if (dout_data !== e_v[0]) begin n_err++; $display("FAIL bp_dout0: got %h want %h", dout_data, e_v[0]); end
        dout_ready = 1'b0; din_data = d_v[1];
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_din_ready%0d: got %b want 0", c, din_ready); end
            tick();
            n_cmp++; if (dout_valid !== 1'b1 || dout_data !== e_v[0] || dout_last !== 1'b0)
                begin n_err++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want 1 %h 0", c, dout_valid, dout_data, dout_last, e_v[0]); end
        end
        dout_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            din_valid = 1'b1; din_data = d_v[i]; din_last = (i == 5);
            tick();
            n_cmp++; if (dout_valid !== 1'b1 || dout_data !== e_v[i] || dout_last !== (i == 5))
                begin n_err++; $display("FAIL bp_dout%0d: got v=%b d=%h l=%b want 1 %h %b", i, dout_valid, dout_data, dout_last, e_v[i], (i == 5)); end
        end
        din_valid = 1'b0; din_last = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b1 || byte_cnt !== 16'd6)
            begin n_err++; $display("FAIL bp_done: got done=%b cnt=%0d want 1 6", done, byte_cnt); end
    endtask

    task automatic test_starvation();
        do_start();
        din_valid = 1'b1; din_data = 8'h5C; din_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (din_ready !== 1'b0 || dout_valid !== 1'b0)
                begin n_err++; $display("FAIL starve_wait%0d: got rdy=%b v=%b want 0 0", c, din_ready, dout_valid); end
            tick();
        end
        ks_valid = 1'b1; ks_data = 8'h3C;
        tick();
        ks_valid = 1'b0;
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL starve_resume: got %b want 1", din_ready); end
        tick();
        din_valid = 1'b0; din_last = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1 || dout_data !== 8'h60 || dout_last !== 1'b1)
            begin n_err++; $display("FAIL starve_dout: got v=%b d=%h l=%b want 1 60 1", dout_valid, dout_data, dout_last); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL starve_done: got %b want 1", done); end
    endtask

    task automatic test_start_and_reset();
        do_start();
        ks_valid = 1'b1; ks_data = 8'h11; tick();
        ks_data = 8'h22; tick();
        ks_valid = 1'b0;
        din_valid = 1'b1; din_data = 8'h01; din_last = 1'b0;
        tick();
        din_valid = 1'b0;
        n_cmp++; if (dout_data !== 8'h10) begin n_err++; $display("FAIL sr_dout0: got %h want 10", dout_data); end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (ks_flush !== 1'b0 || byte_cnt !== 16'd1 || busy !== 1'b1)
            begin n_err++; $display("FAIL sr_start_ignored: got flush=%b cnt=%0d busy=%b want 0 1 1", ks_flush, byte_cnt, busy); end
        din_valid = 1'b1; din_data = 8'h02;
        tick();
        din_valid = 1'b0; dout_ready = 1'b0;
        n_cmp++; if (dout_data !== 8'h20) begin n_err++; $display("FAIL sr_dout1: got %h want 20", dout_data); end
        rst = 1'b1;
        tick();
        n_cmp++; if (dout_valid !== 1'b0 || dout_data !== 8'h00 || busy !== 1'b0 || byte_cnt !== 16'd0 || ks_ready !== 1'b0 || din_ready !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL sr_reset: got v=%b d=%h busy=%b cnt=%0d ksr=%b dr=%b done=%b want all 0", dout_valid, dout_data, busy, byte_cnt, ks_ready, din_ready, done); end
        rst = 1'b0; dout_ready = 1'b1;
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL sr_no_done: got %b want 0", done); end
    endtask

    task automatic run_pass(input logic [7:0] src [64], input logic [7:0] key [64], input logic [7:0] want [64], input string tag);
        do_start();
        for (int i = 0; i < 64; i++) begin
            ks_valid = 1'b1; ks_data = key[i]; din_valid = 1'b0;
            tick();
            ks_valid = 1'b0;
            din_valid = 1'b1; din_data = src[i]; din_last = (i == 63);
            tick();
            din_valid = 1'b0; din_last = 1'b0;
            n_cmp++; if (dout_valid !== 1'b1 || dout_data !== want[i])
                begin n_err++; $display("FAIL %s_byte%0d: got v=%b d=%h want 1 %h", tag, i, dout_valid, dout_data, want[i]); end
        end
        tick();
        n_cmp++; if (done !== 1'b1 || byte_cnt !== 16'd64)
            begin n_err++; $display("FAIL %s_done: got done=%b cnt=%0d want 1 64", tag, done, byte_cnt); end
    endtask

    task automatic test_round_trip();
        logic [7:0] pt [64];
        logic [7:0] ks [64];
        logic [7:0] ct [64];
        for (int i = 0; i < 64; i++) begin
            pt[i] = 8'($urandom);
            ks[i] = 8'($urandom);
            ct[i] = pt[i] ^ ks[i];
        end
        run_pass(pt, ks, ct, "enc");
        run_pass(ct, ks, pt, "dec");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_backpressure();
        test_starvation();
        test_start_and_reset();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
